ps2_time_entry: RTL

//  Consumes the PS/2 receiver's 32-bit keycode shift register and newVal flag, recognises completed key releases
//  (set-2 break sequences), and runs a keypad entry FSM that builds a 24-hour HH:MM value in BCD. It issues a one-cycle

---
 rtl/ps2_time_entry.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/ps2_time_entry.sv
// rtl/ps2_time_entry.sv - PS/2 key-release decoder and HH:MM keypad entry FSM (optional ENTRY_TIMEOUT_EN idle abort)
module ps2_time_entry #(
  parameter int          SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1000000000
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic [31:0] keypress,
  input  logic        newVal,
  output logic        entry_active,
  output logic        entry_target,
  output logic [1:0]  entry_pos,
  output logic [15:0] entry_bcd,
  output logic        entry_full,
  output logic        set_time,
  output logic        set_alarm,
  output logic [15:0] commit_bcd,
  output logic        key_err
);

  typedef enum logic [2:0] {S_IDLE, S_H10, S_H1, S_M10, S_M1, S_FULL} state_t;
  typedef enum logic [2:0] {K_NONE, K_DIGIT, K_T, K_A, K_ENTER, K_BS, K_ESC} key_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   key_evt;
  logic                   accept;
  logic                   timeout;

  state_t      state_q;
  logic        target_q;
  logic [15:0] bcd_q;
  logic [15:0] commit_q;
  logic        set_time_q;
  logic        set_alarm_q;
  logic        key_err_q;

  key_t        kcls;
  logic [3:0]  kdig;
  logic [3:0]  lim;
  logic [1:0]  pos;

  // Only the break prefix and the make code matter; older bytes are history.
  logic unused_keypress;
  assign unused_keypress = ^keypress[31:16];

  // Bring newVal into the system clock domain and keep one extra stage for edge detection
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], newVal};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // newVal falls once the make byte after F0 has arrived; keypress is stable then
  assign key_evt = edge_q & ~sync_q[SYNC_STAGES-1];
  assign accept  = key_evt && (keypress[15:8] == 8'hF0);

  // Translate the set-2 make code into a key class and digit value
  always_comb begin
    kcls = K_NONE;
    kdig = 4'd0;
    case (keypress[7:0])
      8'h45: begin kcls = K_DIGIT; kdig = 4'd0; end
      8'h16: begin kcls = K_DIGIT; kdig = 4'd1; end
      8'h1E: begin kcls = K_DIGIT; kdig = 4'd2; end
      8'h26: begin kcls = K_DIGIT; kdig = 4'd3; end
      8'h25: begin kcls = K_DIGIT; kdig = 4'd4; end
      8'h2E: begin kcls = K_DIGIT; kdig = 4'd5; end
      8'h36: begin kcls = K_DIGIT; kdig = 4'd6; end
      8'h3D: begin kcls = K_DIGIT; kdig = 4'd7; end
      8'h3E: begin kcls = K_DIGIT; kdig = 4'd8; end
      8'h46: begin kcls = K_DIGIT; kdig = 4'd9; end
      8'h2C: kcls = K_T;
      8'h1C: kcls = K_A;
      8'h5A: kcls = K_ENTER;
      8'h66: kcls = K_BS;
      8'h76: kcls = K_ESC;
      default: kcls = K_NONE;
    endcase
  end

  // Digit position and the largest digit allowed there (H1 depends on H10 for 20-23)
  always_comb begin
    pos = 2'd0;
    lim = 4'd9;
    case (state_q)
      S_H10:  begin pos = 2'd0; lim = 4'd2; end
      S_H1:   begin pos = 2'd1; lim = (bcd_q[15:12] == 4'd2) ? 4'd3 : 4'd9; end
      S_M10:  begin pos = 2'd2; lim = 4'd5; end
      S_M1:   begin pos = 2'd3; lim = 4'd9; end
      S_FULL: begin pos = 2'd3; lim = 4'd9; end
      default: begin pos = 2'd0; lim = 4'd9; end
    endcase
  end

`ifdef ENTRY_TIMEOUT_EN
  logic [29:0] idle_q;

  assign timeout = (state_q != S_IDLE) && (idle_q == 30'(TIMEOUT_CYCLES - 1));

  // Idle counter: runs during entry, restarts on any accepted key or on abort
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      idle_q <= '0;
    end else if ((state_q == S_IDLE) || accept || timeout) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_q + 30'd1;
    end
  end
`else
  logic [29:0] unused_timeout;
  assign unused_timeout = 30'(TIMEOUT_CYCLES);
  assign timeout        = 1'b0;
`endif

  // Entry FSM with registered strobes; a key in the same cycle as the timeout takes priority
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q     <= S_IDLE;
      target_q    <= 1'b0;
      bcd_q       <= '0;
      commit_q    <= '0;
      set_time_q  <= 1'b0;
      set_alarm_q <= 1'b0;
      key_err_q   <= 1'b0;
    end else begin
      set_time_q  <= 1'b0;
      set_alarm_q <= 1'b0;
      key_err_q   <= 1'b0;
      if (accept) begin
        case (kcls)
          K_T, K_A: begin
            state_q  <= S_H10;
            target_q <= (kcls == K_A);
            bcd_q    <= '0;
          end
          K_ESC: begin
            if (state_q != S_IDLE) begin
              state_q <= S_IDLE;
              bcd_q   <= '0;
            end
          end
          K_ENTER: begin
            if (state_q == S_FULL) begin
              commit_q    <= bcd_q;
              set_time_q  <= ~target_q;
              set_alarm_q <= target_q;
              state_q     <= S_IDLE;
              bcd_q       <= '0;
            end
          end
          K_BS: begin
            case (state_q)
              S_FULL: begin state_q <= S_M1;  bcd_q[3:0]   <= 4'd0; end
              S_M1:   begin state_q <= S_M10; bcd_q[7:4]   <= 4'd0; end
              S_M10:  begin state_q <= S_H1;  bcd_q[11:8]  <= 4'd0; end
              S_H1:   begin state_q <= S_H10; bcd_q[15:12] <= 4'd0; end
              default: ;
            endcase
          end
          K_DIGIT: begin
            if ((state_q == S_H10) || (state_q == S_H1) ||
                (state_q == S_M10) || (state_q == S_M1)) begin
              if (kdig <= lim) begin
                bcd_q[{~pos, 2'b00} +: 4] <= kdig;
                state_q <= state_t'(state_q + 3'd1);
              end else begin
                key_err_q <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end else if (timeout) begin
        state_q <= S_IDLE;
        bcd_q   <= '0;
      end
    end
  end

  assign entry_active = (state_q != S_IDLE);
  assign entry_full   = (state_q == S_FULL);
  assign entry_target = target_q;
  assign entry_pos    = pos;
  assign entry_bcd    = bcd_q;
  assign commit_bcd   = commit_q;
  assign set_time     = set_time_q;
  assign set_alarm    = set_alarm_q;
  assign key_err      = key_err_q;

endmodule
